// File: rtl/data_memory_sized.sv
// Big-endian byte-addressed data memory with sized, sign/zero-extended accesses.
// Registered 1-cycle reads, fault reporting and a post-reset array clear.
module data_memory_sized #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH_BYTES    = 256,
   parameter int BASE_ADDRESS   = 1024,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_Sig_Memory_Write_Enable,
   input  logic                  i_Sig_Memory_Read_Enable,
   input  logic [1:0]            i_Size,
   input  logic                  i_Sign_Extend,
   input  logic [DATA_WIDTH-1:0] i_Address,
   input  logic [DATA_WIDTH-1:0] i_Write_Data,
   output logic [DATA_WIDTH-1:0] o_Read_Data,
   output logic                  o_Read_Valid,
   output logic                  o_Fault,
   output logic                  o_Busy
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = AW - 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH_BYTES / 4 - 1);

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] mem_q [DEPTH_BYTES];

   logic [DATA_WIDTH-1:0] offset;
   logic [AW-1:0]         idx;
   logic                  busy;
   logic                  req;
   logic                  in_range;
   logic                  misalign;
   logic                  fault;
   logic                  do_write;
   logic                  do_read;
   logic [7:0]            b0, b1, b2, b3;
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
   logic                  rvalid_q;
   logic                  fault_q;

   assign busy     = (state_q == S_CLEAR);
   assign offset   = i_Address - DATA_WIDTH'(BASE_ADDRESS);
   assign idx      = offset[AW-1:0];
   assign in_range = offset < DATA_WIDTH'(DEPTH_BYTES);
   assign req      = (i_Sig_Memory_Write_Enable | i_Sig_Memory_Read_Enable) & ~busy;
   assign fault    = req & (~in_range | misalign | (i_Size == 2'b11));
   assign do_write = i_Sig_Memory_Write_Enable & ~busy & ~fault;
   assign do_read  = i_Sig_Memory_Read_Enable & ~busy;

   always_comb begin
      misalign = 1'b0;
      unique case (i_Size)
         2'b01:   misalign = i_Address[0];
         2'b10:   misalign = |i_Address[1:0];
         default: misalign = 1'b0;
      endcase
   end

   // Index arithmetic may wrap on faulted accesses; those results are discarded.
   always_comb begin
      b0 = mem_q[idx];
      b1 = mem_q[idx + AW'(1)];
      b2 = mem_q[idx + AW'(2)];
      b3 = mem_q[idx + AW'(3)];
      rdata_d = '0;
      unique case (i_Size)
         2'b00:   rdata_d = {{24{i_Sign_Extend & b0[7]}}, b0};
         2'b01:   rdata_d = {{16{i_Sign_Extend & b0[7]}}, b0, b1};
         2'b10:   rdata_d = {b0, b1, b2, b3};
         default: rdata_d = '0;
      endcase
      if (fault) rdata_d = '0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end
         end
         default: state_d = S_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= do_read;
         fault_q  <= fault;
         if (do_read) rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            mem_q[{cnt_q, 2'd0}] <= '0;
            mem_q[{cnt_q, 2'd1}] <= '0;
            mem_q[{cnt_q, 2'd2}] <= '0;
            mem_q[{cnt_q, 2'd3}] <= '0;
         end else if (do_write) begin
            unique case (i_Size)
               2'b00: mem_q[idx] <= i_Write_Data[7:0];
               2'b01: begin
                  mem_q[idx]          <= i_Write_Data[15:8];
                  mem_q[idx + AW'(1)] <= i_Write_Data[7:0];
               end
               2'b10: begin
                  mem_q[idx]          <= i_Write_Data[31:24];
                  mem_q[idx + AW'(1)] <= i_Write_Data[23:16];
                  mem_q[idx + AW'(2)] <= i_Write_Data[15:8];
                  mem_q[idx + AW'(3)] <= i_Write_Data[7:0];
               end
               default: ;
            endcase
         end
      end
   end

   assign o_Read_Data  = rdata_q;
   assign o_Read_Valid = rvalid_q;
   assign o_Fault      = fault_q;
   assign o_Busy       = busy;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: scoreboard of expected read/fault pulses
// plus per-scenario checks of reset, clear timing and ignored requests.
module tb_data_memory_sized;

   logic        clk;
   logic        reset;
   logic        we, re, sx;
   logic [1:0]  sz;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        rvalid, rfault, busy;

   typedef struct {
      int          due;
      bit          valid;
      bit          flt;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   bit   armed = 0;

   data_memory_sized dut (
      .clk                       (clk),
      .reset                     (reset),
      .i_Sig_Memory_Write_Enable (we),
      .i_Sig_Memory_Read_Enable  (re),
      .i_Size                    (sz),
      .i_Sign_Extend             (sx),
      .i_Address                 (addr),
      .i_Write_Data              (wdata),
      .o_Read_Data               (rdata),
      .o_Read_Valid              (rvalid),
      .o_Fault                   (rfault),
      .o_Busy                    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         if (sb.size() != 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL sb_missed: due=%0d now=%0d", e.due, cyc);
         end
         if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (rvalid !== e.valid || rfault !== e.flt ||
                (e.valid && rdata !== e.data)) begin
               bad++;
               $display("FAIL sb_out: got v=%b f=%b d=%h want v=%b f=%b d=%h",
                        rvalid, rfault, rdata, e.valid, e.flt, e.data);
            end
         end else if (rvalid !== 1'b0 || rfault !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got v=%b f=%b want v=0 f=0 at cyc %0d",
                     rvalid, rfault, cyc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, want finish");
      $fatal(1, "watchdog");
   end

   task automatic req(input bit w, input bit r, input logic [1:0] s,
                      input bit x, input logic [31:0] a, input logic [31:0] d,
                      input bit push, input bit ev, input bit ef,
                      input logic [31:0] ed);
      exp_t e;
      we = w; re = r; sz = s; sx = x; addr = a; wdata = d;
      if (push) begin
         e = '{due: cyc + 1, valid: ev, flt: ef, data: ed};
         sb.push_back(e);
      end
      @(negedge clk);
      we = 1'b0;
      re = 1'b0;
   endtask

   task automatic rd(input logic [1:0] s, input bit x, input logic [31:0] a,
                     input logic [31:0] ed);
      req(1'b0, 1'b1, s, x, a, 32'h0, 1'b1, 1'b1, 1'b0, ed);
   endtask

   task automatic rdf(input logic [1:0] s, input logic [31:0] a);
      req(1'b0, 1'b1, s, 1'b0, a, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
   endtask

   task automatic wr(input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] d);
      req(1'b1, 1'b0, s, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic wrf(input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d);
      req(1'b1, 1'b0, s, 1'b0, a, d, 1'b1, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      do_reset();
      total++;
      if (rdata !== 32'h0 || rvalid !== 1'b0 || rfault !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: got d=%h v=%b f=%b b=%b want 0 0 0 1",
                  rdata, rvalid, rfault, busy);
      end
      armed = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (n != 64) begin
         bad++;
         $display("FAIL clear_len: got %0d busy cycles want 64", n);
      end
      rd(2'b10, 1'b0, 32'h400, 32'h0);
   endtask

   task automatic test_word_sub();
      wr(2'b10, 32'h404, 32'h11223344);
      rd(2'b00, 1'b1, 32'h405, 32'h00000022);
      rd(2'b01, 1'b0, 32'h406, 32'h00003344);
      rd(2'b01, 1'b1, 32'h404, 32'h00001122);
      rd(2'b10, 1'b1, 32'h404, 32'h11223344);
      wr(2'b01, 32'h410, 32'h1234BEEF);
      rd(2'b01, 1'b1, 32'h410, 32'hFFFFBEEF);
      rd(2'b01, 1'b0, 32'h410, 32'h0000BEEF);
      rd(2'b10, 1'b0, 32'h410, 32'hBEEF0000);
   endtask

   task automatic test_byte_ext();
      wr(2'b00, 32'h408, 32'hABCDEF80);
      rd(2'b00, 1'b1, 32'h408, 32'hFFFFFF80);
      rd(2'b00, 1'b0, 32'h408, 32'h00000080);
      rd(2'b10, 1'b1, 32'h408, 32'h80000000);
   endtask

   task automatic test_faults();
      rdf(2'b10, 32'h402);
      wrf(2'b01, 32'h401, 32'h0000FFFF);
      rd(2'b10, 32'h0, 32'h400, 32'h0);
      rdf(2'b10, 32'h3FC);
      rdf(2'b00, 32'h500);
      wrf(2'b10, 32'h500, 32'hFFFFFFFF);
      rdf(2'b11, 32'h404);
      rd(2'b00, 1'b0, 32'h4FF, 32'h0);
      rd(2'b10, 1'b0, 32'h4FC, 32'h0);
   endtask

   task automatic test_rw_same();
      wr(2'b10, 32'h40C, 32'hAAAAAAAA);
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h40C, 32'h55555555,
          1'b1, 1'b1, 1'b0, 32'hAAAAAAAA);
      rd(2'b10, 1'b0, 32'h40C, 32'h55555555);
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h402, 32'h0,
          1'b1, 1'b1, 1'b1, 32'h0);
   endtask

   task automatic test_back_to_back();
      wr(2'b10, 32'h420, 32'hCAFEF00D);
      rd(2'b10, 1'b0, 32'h420, 32'hCAFEF00D);
      rd(2'b00, 1'b0, 32'h421, 32'h000000FE);
      rd(2'b00, 1'b1, 32'h422, 32'hFFFFFFF0);
      rd(2'b01, 1'b0, 32'h422, 32'h0000F00D);
      wr(2'b00, 32'h423, 32'h00000077);
      rd(2'b10, 1'b0, 32'h420, 32'hCAFEF077);
   endtask

   task automatic test_mid_clear();
      int n;
      do_reset();
      repeat (30) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_mid: got %b want 1", busy);
      end
      do_reset();
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         we = 1'b0;
         re = 1'b0;
         if (n == 50) begin
            we = 1'b1; sz = 2'b10; addr = 32'h400; wdata = 32'hDEADBEEF;
         end else if (n == 51) begin
            re = 1'b1; sz = 2'b00; addr = 32'h500;
         end else if (n == 52) begin
            we = 1'b1; re = 1'b1; sz = 2'b10; addr = 32'h404;
         end
         n++;
         @(negedge clk);
      end
      we = 1'b0;
      re = 1'b0;
      total++;
      if (n != 64) begin
         bad++;
         $display("FAIL clear_restart: got %0d busy cycles want 64", n);
      end
      rd(2'b10, 1'b0, 32'h400, 32'h0);
      rd(2'b10, 1'b0, 32'h404, 32'h0);
      rd(2'b10, 1'b0, 32'h40C, 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      we = 1'b0; re = 1'b0; sx = 1'b0;
      sz = 2'b00; addr = 32'h0; wdata = 32'h0;
      test_reset();
      test_word_sub();
      test_byte_ext();
      test_faults();
      test_rw_same();
      test_back_to_back();
      test_mid_clear();
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
